bsg_chip_link_reset_sequencer: RTL

//  Sequences the reset bring-up of the chip's IO and memory bsg_link channels.
//  The order is: assert all resets, release upstream IO reset, release downstream reset, release core reset.
//  One instance sits in the core clock domain, fed by bsg_tag-programmed start/mask/delay.
//  Its reset vectors go to per-link synchronizers ahead of bsg_chip_io_links_ct_fifo.
//

---
 rtl/bsg_chip_link_reset_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/bsg_chip_link_reset_sequencer.sv
// bsg_chip_link_reset_sequencer
//
// Brings the chip's bsg_link channels out of reset in a fixed order. On an
// accepted start, every upstream, downstream and core reset bit is asserted
// for one phase. Each enabled link is then released in turn: upstream first,
// then downstream, then core. Every phase lasts delay+1 cycles. Links are
// handled from the lowest index upward, and disabled links are skipped with
// no cycles spent on them.
//
// Configuration macro:
//   BSG_CHIP_LINK_RESET_SEQ_PARALLEL_EN  When defined, all enabled links are
//                                        released together in a single
//                                        UP/DS/CORE pass.
//
// Ports:
//   clk_i         core clock
//   reset_i       synchronous, active-high reset
//   start_i       start request; honoured only when idle or done
//   link_en_i     links to bring up, captured on an accepted start
//   delay_i       phase delay (phase = delay_i+1 cycles), captured on start
//   busy_o        sequence in progress
//   done_o        level, high once a sequence has completed
//   up_reset_o    per-link upstream (io) reset
//   ds_reset_o    per-link downstream reset
//   core_reset_o  per-link core-side reset
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start; all resets asserted
// ASSERT   | all resets asserted for one phase
// UP_REL   | upstream reset of current link(s) released
// DS_REL   | downstream reset of current link(s) released
// CORE_REL | core reset of current link(s) released
// DONE     | sequence complete; released bits stay released

module bsg_chip_link_reset_sequencer #(
    parameter int num_links_p   = 18,
    parameter int delay_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [num_links_p-1:0]   link_en_i,
    input  logic [delay_width_p-1:0] delay_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [num_links_p-1:0]   up_reset_o,
    output logic [num_links_p-1:0]   ds_reset_o,
    output logic [num_links_p-1:0]   core_reset_o
);

    localparam logic [num_links_p-1:0]   all_ones_lp = '1;
    localparam logic [num_links_p-1:0]   lsb_lp      = num_links_p'(1);
    localparam logic [delay_width_p-1:0] cnt_one_lp  = delay_width_p'(1);

    typedef enum logic [2:0] {
        e_idle,
        e_assert,
        e_up_rel,
        e_ds_rel,
        e_core_rel,
        e_done
    } state_e;

    state_e                   state_r, state_n;
    logic [num_links_p-1:0]   mask_r, mask_n;
    logic [num_links_p-1:0]   cur_r, cur_n;
    logic [num_links_p-1:0]   up_r, up_n;
    logic [num_links_p-1:0]   ds_r, ds_n;
    logic [num_links_p-1:0]   core_r, core_n;
    logic [delay_width_p-1:0] dly_r, dly_n;
    logic [delay_width_p-1:0] cnt_r, cnt_n;
    logic                     busy_r, busy_n;
    logic                     done_r, done_n;

    logic                     phase_end;
    logic [num_links_p-1:0]   mask_rest;
    logic [num_links_p-1:0]   first_sel;
    logic [num_links_p-1:0]   next_sel;

    assign phase_end = (cnt_r == '0);
    assign mask_rest = mask_r & ~cur_r;

`ifdef BSG_CHIP_LINK_RESET_SEQ_PARALLEL_EN
    // Every enabled link forms one group, so nothing is left after CORE_REL.
    assign first_sel = mask_r;
    assign next_sel  = '0;
`else
    // x & -x isolates the lowest set bit, which is the next link to bring up.
    assign first_sel = mask_r & (~mask_r + lsb_lp);
    assign next_sel  = mask_rest & (~mask_rest + lsb_lp);
`endif

    always_comb begin
        state_n = state_r;
        mask_n  = mask_r;
        cur_n   = cur_r;
        up_n    = up_r;
        ds_n    = ds_r;
        core_n  = core_r;
        dly_n   = dly_r;
        cnt_n   = cnt_r;
        busy_n  = busy_r;
        done_n  = done_r;

        unique case (state_r)
            e_idle, e_done: begin
                if (start_i) begin
                    state_n = e_assert;
                    mask_n  = link_en_i;
                    cur_n   = '0;
                    dly_n   = delay_i;
                    // dly_r is not loaded yet, so take the count from the input.
                    cnt_n   = delay_i;
                    up_n    = all_ones_lp;
                    ds_n    = all_ones_lp;
                    core_n  = all_ones_lp;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end

            e_assert: begin
                if (phase_end) begin
                    cnt_n = dly_r;
                    if (mask_r == '0) begin
                        state_n = e_done;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = e_up_rel;
                        cur_n   = first_sel;
                        up_n    = up_r & ~first_sel;
                    end
                end else begin
                    cnt_n = cnt_r - cnt_one_lp;
                end
            end

            e_up_rel: begin
                if (phase_end) begin
                    cnt_n   = dly_r;
                    state_n = e_ds_rel;
                    ds_n    = ds_r & ~cur_r;
                end else begin
                    cnt_n = cnt_r - cnt_one_lp;
                end
            end

            e_ds_rel: begin
                if (phase_end) begin
                    cnt_n   = dly_r;
                    state_n = e_core_rel;
                    core_n  = core_r & ~cur_r;
                end else begin
                    cnt_n = cnt_r - cnt_one_lp;
                end
            end

            e_core_rel: begin
                if (phase_end) begin
                    cnt_n  = dly_r;
                    mask_n = mask_rest;
                    if (next_sel != '0) begin
                        state_n = e_up_rel;
                        cur_n   = next_sel;
                        up_n    = up_r & ~next_sel;
                    end else begin
                        state_n = e_done;
                        cur_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r - cnt_one_lp;
                end
            end

            default: begin
                state_n = e_idle;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            mask_r  <= '0;
            cur_r   <= '0;
            up_r    <= all_ones_lp;
            ds_r    <= all_ones_lp;
            core_r  <= all_ones_lp;
            dly_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            mask_r  <= mask_n;
            cur_r   <= cur_n;
            up_r    <= up_n;
            ds_r    <= ds_n;
            core_r  <= core_n;
            dly_r   <= dly_n;
            cnt_r   <= cnt_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign up_reset_o   = up_r;
    assign ds_reset_o   = ds_r;
    assign core_reset_o = core_r;

endmodule
